// File: rtl/pulse_pkg.sv
// Shared types and helpers for the programmable pulse-train generator.
package pulse_pkg;

  localparam int unsigned CLAMP_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    GAP   = 2'd3
  } pulse_state_t;

  // A zero-length high or gap phase still lasts one cycle.
  function automatic logic [CLAMP_W-1:0] clamp1(input logic [CLAMP_W-1:0] x);
    return (x == '0) ? CLAMP_W'(1) : x;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable phase down-counter: load of N gives an expire after N cycles.
module pulse_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = val - WIDTH'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/pulse_train.sv
// Programmable pulse-train generator: delay, then count pulses of len high / gap low.
module pulse_train
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned RETRIG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] dly,
  input  logic [WIDTH-1:0] len,
  input  logic [WIDTH-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pcnt
);

  pulse_state_t     state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d, gap_q, gap_d;
  logic [CNT_W-1:0] count_q, count_d, pcnt_q, pcnt_d;
  logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;

  logic             tmr_load, tmr_expire;
  logic [WIDTH-1:0] tmr_val;
  logic [WIDTH-1:0] len_c, gap_c;
  logic [CNT_W-1:0] pcnt_inc_c;
  logic             start_ok_c;

  assign len_c      = WIDTH'(clamp1(CLAMP_W'(len)));
  assign gap_c      = WIDTH'(clamp1(CLAMP_W'(gap)));
  assign pcnt_inc_c = pcnt_q + CNT_W'(1);
  assign start_ok_c = start && ((state_q == IDLE) || (RETRIG != 0));

  pulse_timer #(.WIDTH(WIDTH)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .val    (tmr_val),
    .expire (tmr_expire)
  );

  // Next-state, timer control and registered-output decode.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    gap_d    = gap_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (stop) begin
      state_d = IDLE;
    end else if (start_ok_c) begin
      len_d    = len_c;
      gap_d    = gap_c;
      count_d  = count;
      pcnt_d   = '0;
      tmr_load = 1'b1;
      if (dly != '0) begin
        state_d = DELAY;
        tmr_val = dly;
      end else begin
        state_d = HIGH;
        tmr_val = len_c;
      end
    end else begin
      case (state_q)
        DELAY, GAP: begin
          if (tmr_expire) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = len_q;
          end
        end
        HIGH: begin
          if (tmr_expire) begin
            pcnt_d = pcnt_inc_c;
            if ((count_q != '0) && (pcnt_inc_c == count_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = gap_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      count_q <= '0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pcnt  = pcnt_q;

endmodule
